count_monitor: RTL
==================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter CNT_W, default 3: width of the monitored count.
REQ-002 Parameter WRAP_W, default 8: width of the wrap statistics counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  monitor enable; count_i is sampled only in cycles with en=1.
REQ-006 clr  input  1  synchronous clear of error, statistics and state.
REQ-007 count_i  input  CNT_W  free-running count from the upstream counter stage.
REQ-008 wrap_o  output  1  registered one-cycle pulse per detected wrap (max -> 0).
REQ-009 wraps_o  output  WRAP_W  saturating number of wraps detected since reset/clr.
REQ-010 sat_o  output  1  high while wraps_o equals 2^WRAP_W-1.
REQ-011 err_o  output  1  sticky sequence-error flag.
REQ-012 last_o  output  CNT_W  last accepted count sample.

Function
REQ-013 The FSM SHALL have exactly three states: SYNC, TRACK, FAULT.
REQ-014 SYNC, en=1: last_o <= count_i, go TRACK; no check and no wrap detection on this sample.
REQ-015 TRACK, en=1, count_i == (last_o+1) mod 2^CNT_W: last_o <= count_i, stay TRACK.
REQ-016 TRACK, en=1, last_o == 2^CNT_W-1 and count_i == 0: wrap_o=1 in the next cycle; wraps_o increments in that same cycle.
REQ-017 TRACK, en=1, any other count_i: err_o <= 1, go FAULT; last_o not updated; no wrap pulse.
REQ-018 TRACK or SYNC, en=0: go SYNC, last_o held; skipped samples never produce an error.
REQ-019 FAULT: remain until clr or reset regardless of en/count_i; wraps_o, last_o and err_o frozen; wrap_o=0.
REQ-020 clr=1: next cycle state=SYNC, err_o=0, wraps_o=0, wrap_o=0; last_o held; clr beats any same-cycle wrap or error.
REQ-021 wraps_o SHALL saturate at 2^WRAP_W-1 and never roll over; wrap_o still pulses on every wrap while saturated.
REQ-022 Latency SHALL be exactly one cycle from the sampling edge to wrap_o, err_o and wraps_o update; all outputs registered.
REQ-023 The count comparison SHALL be computed modulo 2^CNT_W, with no width extension.

Reset
REQ-024 rst_n low SHALL immediately force state=SYNC, wrap_o=0, wraps_o=0, sat_o=0, err_o=0, last_o=0.
REQ-025 Reset asserted mid-operation SHALL discard any pending wrap/error; after deassertion the first enabled sample is a SYNC sample.

Structure
REQ-026 A shared package count_pkg SHALL hold the state enum (MON_SYNC, MON_TRACK, MON_FAULT) and the default CNT_W constant.
REQ-027 The saturating wrap counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst_n, clr, inc; outputs value, sat).
REQ-028 No other sub-modules; the FSM and compare logic live in count_monitor.

Verification
REQ-029 Reset, en=1, count_i 0,1,...,7,0 -> wrap_o single pulse the cycle after the 0 sample, wraps_o=1, err_o=0.
REQ-030 TRACK with count_i 2,3,5 -> err_o=1 the cycle after 5; state FAULT; later valid 6,7,0 produces no wrap_o and wraps_o is unchanged.
REQ-031 FAULT, clr=1 for one cycle -> err_o=0, wraps_o=0 next cycle; clr asserted together with a 7->0 sample -> no wrap_o, wraps_o=0.
REQ-032 WRAP_W=2, five consecutive full wraps -> wraps_o=3, sat_o=1 from the third wrap, wrap_o pulses five times.
REQ-033 en=0 for 3 cycles while count_i advances by 3, then en=1 -> no err_o; the first sample is taken in SYNC; wrap detection resumes from the next sample.
REQ-034 rst_n pulsed low in TRACK immediately after a 7->0 sample -> wrap_o stays 0 and all outputs read 0 during reset.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and defaults for the count monitor slice.
// Pure declarations; no clocked logic; no flow control.
package count_pkg;

    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        MON_SYNC  = 2'd0,
        MON_TRACK = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a registered saturation flag.
// Latency: value/sat update one cycle after inc; clr has priority; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc && (value != MAX)) begin
            value <= value + 1'b1;
            sat   <= (value == MAX - 1'b1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Checks an upstream free-running count for +1 steps, counts wraps, flags errors.
// Latency: one cycle from sampling edge to every output; no backpressure (en gates sampling).
module count_monitor
    import count_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [CNT_W-1:0]  count_i,
    output logic              wrap_o,
    output logic [WRAP_W-1:0] wraps_o,
    output logic              sat_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  last_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] next_exp;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    // Stays CNT_W wide so max+1 folds back to zero.
    assign next_exp = last_q + 1'b1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wrap_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            MON_SYNC: begin
                if (en) begin
                    last_d  = count_i;
                    state_d = MON_TRACK;
                end
            end
            MON_TRACK: begin
                if (!en) begin
                    state_d = MON_SYNC;
                end else if (count_i == next_exp) begin
                    last_d = count_i;
                    wrap_d = (last_q == CNT_MAX);
                end else begin
                    err_d   = 1'b1;
                    state_d = MON_FAULT;
                end
            end
            MON_FAULT: begin
                state_d = MON_FAULT;
            end
            default: begin
                state_d = MON_SYNC;
            end
        endcase
        // Clear overrides any same-cycle wrap or error but keeps the last sample.
        if (clr) begin
            state_d = MON_SYNC;
            last_d  = last_q;
            wrap_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MON_SYNC;
            last_q  <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wraps (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (wrap_d),
        .value (wraps_o),
        .sat   (sat_o)
    );

    assign wrap_o = wrap_q;
    assign err_o  = err_q;
    assign last_o = last_q;

endmodule
